// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frame-level command parser behind the UART byte receiver.
// Frames of HEADER, ADDR, DHI, DLO[, CHK] become one 16-bit config write
// over a req/ack handshake. Malformed frames, inter-byte timeouts and
// overruns are reported as single-cycle error pulses.
//
// Build option: define UART_CMD_CHECKSUM_EN to enable the CHK byte and the
// checksum compare. Without it the frame is 4 bytes and chk_err is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | hunting for HEADER, other bytes dropped silently
// S_ADDR  | waiting for the register address byte
// S_DHI   | waiting for the data high byte
// S_DLO   | waiting for the data low byte
// S_CHK   | waiting for the checksum byte (checksum build only)
// S_WRITE | cfg_wr_req held high until cfg_wr_ack

module uart_cmd_ctrl #(
  parameter logic [7:0] HEADER         = 8'h55,
  parameter int         TIMEOUT_CYCLES = 500_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  output logic        cfg_wr_req,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  input  logic        cfg_wr_ack,
  output logic        chk_err,
  output logic        tmo_err,
  output logic        ovr_err
);

  localparam int               CNT_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_CHK, S_WRITE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DHI, S_DLO, S_WRITE
  } state_t;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;
  logic [7:0]        sh_addr, sh_addr_nxt;
  logic [7:0]        sh_dhi, sh_dhi_nxt;
  logic              req_nxt;
  logic [7:0]        addr_nxt;
  logic [15:0]       wdata_nxt;
  logic              tmo_nxt;
  logic              ovr_nxt;
  logic              in_frame;
  logic              tmo_hit;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]        sh_dlo, sh_dlo_nxt;
  logic [7:0]        chk_sum;
  logic              chk_nxt;

  // running sum of the captured frame bytes, compared against CHK
  assign chk_sum = sh_addr + sh_dhi + sh_dlo;
`else
  assign chk_err = 1'b0;
`endif

  // the timeout only runs while a frame is partially received
  assign in_frame = (state != S_IDLE) && (state != S_WRITE);
  // a byte on the terminal-count cycle wins over the timeout
  assign tmo_hit  = in_frame && !rx_flag && (tmo_cnt == CNT_TC);

  // next-state, shadow capture and registered-output values
  always_comb begin
    state_nxt   = state;
    sh_addr_nxt = sh_addr;
    sh_dhi_nxt  = sh_dhi;
    req_nxt     = cfg_wr_req;
    addr_nxt    = cfg_addr;
    wdata_nxt   = cfg_wdata;
    tmo_nxt     = 1'b0;
    ovr_nxt     = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    sh_dlo_nxt  = sh_dlo;
    chk_nxt     = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (rx_flag && (rx_data == HEADER)) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (rx_flag) begin
          sh_addr_nxt = rx_data;
          state_nxt   = S_DHI;
        end
      end
      S_DHI: begin
        if (rx_flag) begin
          sh_dhi_nxt = rx_data;
          state_nxt  = S_DLO;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      S_DLO: begin
        if (rx_flag) begin
          sh_dlo_nxt = rx_data;
          state_nxt  = S_CHK;
        end
      end
      S_CHK: begin
        if (rx_flag) begin
          if (rx_data == chk_sum) begin
            addr_nxt  = sh_addr;
            wdata_nxt = {sh_dhi, sh_dlo};
            req_nxt   = 1'b1;
            state_nxt = S_WRITE;
          end else begin
            chk_nxt   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
`else
      S_DLO: begin
        if (rx_flag) begin
          addr_nxt  = sh_addr;
          wdata_nxt = {sh_dhi, rx_data};
          req_nxt   = 1'b1;
          state_nxt = S_WRITE;
        end
      end
`endif
      S_WRITE: begin
        if (cfg_wr_ack) begin
          // a byte landing on the ack cycle is treated as an IDLE byte
          req_nxt   = 1'b0;
          state_nxt = (rx_flag && (rx_data == HEADER)) ? S_ADDR : S_IDLE;
        end else if (rx_flag) begin
          ovr_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (tmo_hit) begin
      tmo_nxt   = 1'b1;
      state_nxt = S_IDLE;
    end

    if (rx_flag || !in_frame || tmo_hit) tmo_cnt_nxt = '0;
    else                                 tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
  end

  // state, shadows, timer and all outputs are registered here
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      tmo_cnt    <= '0;
      sh_addr    <= '0;
      sh_dhi     <= '0;
      cfg_wr_req <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      tmo_err    <= 1'b0;
      ovr_err    <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      sh_dlo     <= '0;
      chk_err    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      sh_addr    <= sh_addr_nxt;
      sh_dhi     <= sh_dhi_nxt;
      cfg_wr_req <= req_nxt;
      cfg_addr   <= addr_nxt;
      cfg_wdata  <= wdata_nxt;
      tmo_err    <= tmo_nxt;
      ovr_err    <= ovr_nxt;
`ifdef UART_CMD_CHECKSUM_EN
      sh_dlo     <= sh_dlo_nxt;
      chk_err    <= chk_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: table of frame vectors, hand-written corner
// sequences (timeout, terminal-count byte, overrun, garbage, reset) and a
// randomized phase checked every cycle against a frame-level reference model.
// Follows UART_CMD_CHECKSUM_EN to pick the 4- or 5-byte frame.

module tb_uart_cmd_ctrl;

  localparam logic [7:0] HDR = 8'h55;
  localparam int         TMO = 100;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int FLEN = 5;
  localparam bit CSUM = 1'b1;
`else
  localparam int FLEN = 4;
  localparam bit CSUM = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic        cfg_wr_req;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_wr_ack;
  logic        chk_err;
  logic        tmo_err;
  logic        ovr_err;

  uart_cmd_ctrl #(.HEADER(HDR), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .cfg_wr_req(cfg_wr_req),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_wr_ack(cfg_wr_ack),
    .chk_err   (chk_err),
    .tmo_err   (tmo_err),
    .ovr_err   (ovr_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_chk = 0, cnt_tmo = 0, cnt_ovr = 0;
  logic [7:0]  last_addr  = 8'h00;
  logic [15:0] last_wdata = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit         m_in_frame = 1'b0;
  logic [7:0] m_q[$];
  int         m_idle = 0;
  bit         m_pend = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [15:0] m_wdata = 16'h0000;
  bit         m_chk = 1'b0, m_tmo = 1'b0, m_ovr = 1'b0;
  bit         mdl_en = 1'b0;

  task automatic m_start();
    m_in_frame = 1'b1;
    m_q.delete();
    m_idle = 0;
  endtask

  task automatic model_step();
    logic [7:0] s;
    if (!sys_rst_n) begin
      m_in_frame = 1'b0; m_q.delete(); m_idle = 0; m_pend = 1'b0;
      m_addr = 8'h00; m_wdata = 16'h0000;
      m_chk = 1'b0; m_tmo = 1'b0; m_ovr = 1'b0;
      return;
    end
    m_chk = 1'b0; m_tmo = 1'b0; m_ovr = 1'b0;
    if (m_pend) begin
      if (cfg_wr_ack) begin
        m_pend = 1'b0;
        if (rx_flag && rx_data == HDR) m_start();
      end else if (rx_flag) begin
        m_ovr = 1'b1;
      end
    end else if (!m_in_frame) begin
      if (rx_flag && rx_data == HDR) m_start();
    end else if (rx_flag) begin
      m_q.push_back(rx_data);
      m_idle = 0;
      if (m_q.size() == FLEN - 1) begin
        m_in_frame = 1'b0;
        s = m_q[0] + m_q[1] + m_q[2];
        if (!CSUM || m_q[3] == s) begin
          m_pend  = 1'b1;
          m_addr  = m_q[0];
          m_wdata = {m_q[1], m_q[2]};
        end else begin
          m_chk = 1'b1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_tmo = 1'b1;
        m_in_frame = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    model_step();
  end

  initial forever begin
    @(negedge sys_clk);
    if (mdl_en && sys_rst_n) begin
      chk("mdl_req",   32'(cfg_wr_req), 32'(m_pend));
      chk("mdl_addr",  32'(cfg_addr),   32'(m_addr));
      chk("mdl_wdata", 32'(cfg_wdata),  32'(m_wdata));
      chk("mdl_chk",   32'(chk_err),    32'(m_chk));
      chk("mdl_tmo",   32'(tmo_err),    32'(m_tmo));
      chk("mdl_ovr",   32'(ovr_err),    32'(m_ovr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic f, input logic [7:0] d, input logic a);
    rx_flag = f; rx_data = d; cfg_wr_ack = a;
    @(posedge sys_clk);
    #1;
    cnt_chk += int'(chk_err);
    cnt_tmo += int'(tmo_err);
    cnt_ovr += int'(ovr_err);
    rx_flag = 1'b0; cfg_wr_ack = 1'b0;
  endtask

  task automatic clr_cnt();
    cnt_chk = 0; cnt_tmo = 0; cnt_ovr = 0;
  endtask

  task automatic pulse_reset(input string nm);
    #2 sys_rst_n = 1'b0;
    #1;
    chk({nm, "_req"},   32'(cfg_wr_req), 0);
    chk({nm, "_addr"},  32'(cfg_addr),   0);
    chk({nm, "_wdata"}, 32'(cfg_wdata),  0);
    chk({nm, "_errs"},  32'({chk_err, tmo_err, ovr_err}), 0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    last_addr = 8'h00; last_wdata = 16'h0000;
  endtask

  typedef struct {
    logic [0:4][7:0] b;
    int              n;
    int              ack_dly;
    bit              exp_wr;
    logic [7:0]      exp_addr;
    logic [15:0]     exp_wdata;
    int              exp_chk;
  } rec_t;

  rec_t tbl[$];

  function automatic rec_t mk(input logic [39:0] bytes, input int n, input int ad,
                              input bit wr, input logic [7:0] a, input logic [15:0] w,
                              input int c);
    rec_t r;
    r.b = bytes; r.n = n; r.ack_dly = ad; r.exp_wr = wr;
    r.exp_addr = a; r.exp_wdata = w; r.exp_chk = c;
    return r;
  endfunction

  task automatic run_rec(input rec_t r, input int idx);
    string p;
    p = $sformatf("tbl%0d", idx);
    clr_cnt();
    for (int i = 0; i < r.n; i++) tick(1'b1, r.b[i], 1'b0);
    if (r.exp_wr) begin
      chk({p, "_req_rise"}, 32'(cfg_wr_req), 1);
      chk({p, "_addr"},     32'(cfg_addr),   32'(r.exp_addr));
      chk({p, "_wdata"},    32'(cfg_wdata),  32'(r.exp_wdata));
      for (int k = 0; k < r.ack_dly; k++) begin
        tick(1'b0, 8'h00, 1'b0);
        chk({p, "_req_hold"}, 32'(cfg_wr_req), 1);
      end
      tick(1'b0, 8'h00, 1'b1);
      chk({p, "_req_fall"}, 32'(cfg_wr_req), 0);
      last_addr = r.exp_addr; last_wdata = r.exp_wdata;
    end else begin
      chk({p, "_no_req"}, 32'(cfg_wr_req), 0);
    end
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk({p, "_chk_cnt"},  32'(cnt_chk), 32'(r.exp_chk));
    chk({p, "_tmo_cnt"},  32'(cnt_tmo), 0);
    chk({p, "_ovr_cnt"},  32'(cnt_ovr), 0);
    chk({p, "_idle_req"}, 32'(cfg_wr_req), 0);
    chk({p, "_keep_addr"},  32'(cfg_addr),  32'(last_addr));
    chk({p, "_keep_wdata"}, 32'(cfg_wdata), 32'(last_wdata));
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    tick(1'b1, HDR, 1'b0);
    tick(1'b1, a, 1'b0);
    tick(1'b1, h, 1'b0);
    tick(1'b1, l, 1'b0);
    if (CSUM) tick(1'b1, 8'(a + h + l), 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int first;
    int gap;
    logic [7:0] pq[$];
    logic [7:0] ra, rh, rl;
    rx_flag = 1'b0; rx_data = 8'h00; cfg_wr_ack = 1'b0; sys_rst_n = 1'b0;

`ifdef UART_CMD_CHECKSUM_EN
    tbl.push_back(mk({8'h55, 8'h12, 8'hAB, 8'hCD, 8'h8A}, 5, 3, 1, 8'h12, 16'hABCD, 0));
    tbl.push_back(mk({8'h55, 8'h12, 8'hAB, 8'hCD, 8'h8B}, 5, 0, 0, 8'h00, 16'h0000, 1));
    tbl.push_back(mk({8'h55, 8'h12, 8'h00, 8'h01, 8'h13}, 5, 0, 1, 8'h12, 16'h0001, 0));
    tbl.push_back(mk({8'h55, 8'h55, 8'h55, 8'h55, 8'hFF}, 5, 1, 1, 8'h55, 16'h5555, 0));
    tbl.push_back(mk({8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFD}, 5, 2, 1, 8'hFF, 16'hFFFF, 0));
    tbl.push_back(mk({8'h55, 8'h00, 8'h00, 8'h00, 8'h01}, 5, 0, 0, 8'h00, 16'h0000, 1));
`else
    tbl.push_back(mk({8'h55, 8'h12, 8'hAB, 8'hCD, 8'h00}, 4, 3, 1, 8'h12, 16'hABCD, 0));
    tbl.push_back(mk({8'h55, 8'h34, 8'h00, 8'h7F, 8'h00}, 4, 2, 1, 8'h34, 16'h007F, 0));
    tbl.push_back(mk({8'h55, 8'h55, 8'h55, 8'h55, 8'h00}, 4, 0, 1, 8'h55, 16'h5555, 0));
    tbl.push_back(mk({8'h55, 8'hFF, 8'h00, 8'h01, 8'h00}, 4, 1, 1, 8'hFF, 16'h0001, 0));
`endif

    repeat (2) @(posedge sys_clk);
    #2;
    chk("rst_req",   32'(cfg_wr_req), 0);
    chk("rst_addr",  32'(cfg_addr),   0);
    chk("rst_wdata", 32'(cfg_wdata),  0);
    chk("rst_errs",  32'({chk_err, tmo_err, ovr_err}), 0);
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    mdl_en = 1'b1;

    // table vectors
    for (int i = 0; i < tbl.size(); i++) run_rec(tbl[i], i);

    // garbage in IDLE
    clr_cnt();
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'hFF, 1'b0);
    tick(1'b1, 8'h54, 1'b0);
    repeat (2) tick(1'b0, 8'h00, 1'b0);
    chk("garb_req",   32'(cfg_wr_req), 0);
    chk("garb_addr",  32'(cfg_addr),   32'(last_addr));
    chk("garb_wdata", 32'(cfg_wdata),  32'(last_wdata));
    chk("garb_errs",  32'(cnt_chk + cnt_tmo + cnt_ovr), 0);

    // inter-byte timeout
    clr_cnt();
    first = -1;
    tick(1'b1, HDR, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    for (int j = 1; j <= TMO + 5; j++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (tmo_err && first < 0) first = j;
    end
    chk("tmo_at_cycle", 32'(first), 32'(TMO));
    chk("tmo_pulses",   32'(cnt_tmo), 1);
    tick(1'b1, 8'h13, 1'b0);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk("tmo_stray_req", 32'(cfg_wr_req), 0);
    run_rec(tbl[0], 100);

    // byte arriving on the terminal-count cycle wins
    clr_cnt();
    tick(1'b1, HDR, 1'b0);
    tick(1'b1, 8'h21, 1'b0);
    repeat (TMO - 1) tick(1'b0, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    if (CSUM) tick(1'b1, 8'h23, 1'b0);
    chk("tc_req",   32'(cfg_wr_req), 1);
    chk("tc_addr",  32'(cfg_addr),   32'h21);
    chk("tc_wdata", 32'(cfg_wdata),  32'h0002);
    chk("tc_no_tmo", 32'(cnt_tmo), 0);
    tick(1'b0, 8'h00, 1'b1);
    last_addr = 8'h21; last_wdata = 16'h0002;

    // overrun while write pending, then header on the ack cycle
    clr_cnt();
    send_frame(8'h12, 8'hAB, 8'hCD);
    chk("ovr_req_up", 32'(cfg_wr_req), 1);
    tick(1'b1, HDR, 1'b0);
    chk("ovr_pulse", 32'(ovr_err), 1);
    chk("ovr_req_held", 32'(cfg_wr_req), 1);
    chk("ovr_addr", 32'(cfg_addr), 32'h12);
    chk("ovr_wdata", 32'(cfg_wdata), 32'hABCD);
    tick(1'b0, 8'h00, 1'b0);
    chk("ovr_one_cycle", 32'(ovr_err), 0);
    tick(1'b1, HDR, 1'b1);
    chk("ack_hdr_no_ovr", 32'(ovr_err), 0);
    chk("ack_hdr_req_low", 32'(cfg_wr_req), 0);
    tick(1'b1, 8'h12, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h01, 1'b0);
    if (CSUM) tick(1'b1, 8'h13, 1'b0);
    chk("ack_hdr_req", 32'(cfg_wr_req), 1);
    chk("ack_hdr_addr", 32'(cfg_addr), 32'h12);
    chk("ack_hdr_wdata", 32'(cfg_wdata), 32'h0001);
    tick(1'b0, 8'h00, 1'b1);
    chk("ovr_total", 32'(cnt_ovr), 1);
    last_addr = 8'h12; last_wdata = 16'h0001;

    // reset mid-frame
    tick(1'b1, HDR, 1'b0);
    tick(1'b1, 8'h12, 1'b0);
    pulse_reset("rst_frame");
    run_rec(tbl[0], 101);

    // reset mid-WRITE
    send_frame(8'h66, 8'h01, 8'h02);
    chk("rst_wr_req_up", 32'(cfg_wr_req), 1);
    pulse_reset("rst_write");
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    chk("rst_wr_dropped", 32'(cfg_wr_req), 0);
    run_rec(tbl[0], 102);

    // randomized traffic against the reference model
    gap = 0;
    for (int c = 0; c < 4000; c++) begin
      logic ackr;
      int r;
      ackr = ($urandom_range(0, 3) == 0);
      if (pq.size() == 0) begin
        r = $urandom_range(0, 9);
        ra = 8'($urandom_range(0, 255));
        rh = 8'($urandom_range(0, 255));
        rl = 8'($urandom_range(0, 255));
        if (r < 6) begin
          pq.push_back(HDR); pq.push_back(ra); pq.push_back(rh); pq.push_back(rl);
          if (CSUM) pq.push_back((r == 5) ? 8'(ra + rh + rl + 8'd1) : 8'(ra + rh + rl));
        end else if (r < 8) begin
          pq.push_back(ra);
        end else if (r == 8) begin
          pq.push_back(HDR); pq.push_back(ra);
          gap = $urandom_range(TMO - 3, TMO + 3);
        end else begin
          gap = $urandom_range(TMO - 3, TMO + 3);
          pq.push_back(HDR);
        end
      end
      if (gap > 0 && pq.size() == 0) begin
        gap--;
        tick(1'b0, 8'h00, ackr);
      end else if (gap > 0 && pq[0] != HDR) begin
        gap--;
        tick(1'b0, 8'h00, ackr);
      end else if ($urandom_range(0, 2) != 0) begin
        tick(1'b1, pq.pop_front(), ackr);
      end else begin
        tick(1'b0, 8'h00, ackr);
      end
    end

    repeat (3) tick(1'b0, 8'h00, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
